// File: rtl/mips_mem_pkg.sv
// Shared constants, SRAM strobe patterns and FSM states for the data-memory
// arbiter of the SingleCycleMIPS_FPU datapath.
package mips_mem_pkg;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    // {CEN, WEN, OEN}, all active-low
    typedef logic [2:0] strobe_t;
    localparam strobe_t STB_IDLE  = 3'b111;
    localparam strobe_t STB_READ  = 3'b010;
    localparam strobe_t STB_WRITE = 3'b001;

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT1 = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin decision: one-hot grant, the port that did not
// win last time takes a contested cycle.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single synchronous data-SRAM port between the integer (port 0)
// and FPU (port 1) load/store paths, with two-beat double-word sequencing.
module dmem_arbiter #(
    parameter int unsigned AW = mips_mem_pkg::AW,
    parameter int unsigned DW = mips_mem_pkg::DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic            m0_dbl,
    input  logic [AW-1:0]   m0_addr,
    input  logic [2*DW-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic            m1_dbl,
    input  logic [AW-1:0]   m1_addr,
    input  logic [2*DW-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            CEN,
    output logic            WEN,
    output logic            OEN,
    output logic [AW-1:0]   A,
    output logic [DW-1:0]   Data2Mem,
    input  logic [DW-1:0]   ReadDataMem
);

    import mips_mem_pkg::*;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            r_owner;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_rd_pend;
    logic            r_rd_owner;

    logic [1:0]      w_arb_gnt;
    logic            w_win;
    logic            w_any;
    logic            w_we;
    logic            w_dbl;
    logic [AW-1:0]   w_addr;
    logic [2*DW-1:0] w_wdata;

    logic            w_issue;
    logic            w_iss_owner;
    logic            w_iss_we;
    logic [AW-1:0]   w_iss_addr;
    logic [DW-1:0]   w_iss_data;
    logic [1:0]      w_gnt;
    strobe_t         w_stb;

    rr_arb2 u_arb (
        .i_req  ({m1_req, m0_req}),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt)
    );

    assign w_win   = w_arb_gnt[1];
    assign w_any   = |w_arb_gnt;
    assign w_we    = w_win ? m1_we    : m0_we;
    assign w_dbl   = w_win ? m1_dbl   : m0_dbl;
    assign w_addr  = w_win ? m1_addr  : m0_addr;
    assign w_wdata = w_win ? m1_wdata : m0_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_iss_owner = 1'b0;
        w_iss_we    = 1'b0;
        w_iss_addr  = '0;
        w_iss_data  = '0;
        w_gnt       = '0;
        case (r_state)
            IDLE: begin
                // Gated by reset so a held request cannot leak a grant while reset is high
                if (w_any && !rst_n) begin
                    w_issue     = 1'b1;
                    w_iss_owner = w_win;
                    w_iss_we    = w_we;
                    w_iss_addr  = w_addr;
                    w_iss_data  = w_wdata[DW-1:0];
                    if (w_dbl) begin
                        w_state_nxt = BEAT1;
                    end else begin
                        w_gnt[w_win] = 1'b1;
                    end
                end
            end
            BEAT1: begin
                w_issue        = 1'b1;
                w_iss_owner    = r_owner;
                w_iss_we       = r_we;
                w_iss_addr     = r_addr;
                w_iss_data     = r_wdata;
                w_gnt[r_owner] = 1'b1;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_stb         = !w_issue ? STB_IDLE : (w_iss_we ? STB_WRITE : STB_READ);
    assign {CEN, WEN, OEN} = w_stb;
    assign A             = w_issue ? w_iss_addr : '0;
    assign Data2Mem      = (w_issue && w_iss_we) ? w_iss_data : '0;
    assign m0_gnt        = w_gnt[0];
    assign m1_gnt        = w_gnt[1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_pend  <= w_issue && !w_iss_we;
            r_rd_owner <= w_iss_owner;
            if (|w_gnt) begin
                r_last <= w_iss_owner;
            end
            if (r_state == IDLE && w_issue && w_dbl) begin
                r_owner <= w_win;
                r_we    <= w_we;
                r_addr  <= w_addr + 1'b1;
                r_wdata <= w_wdata[2*DW-1:DW];
            end
        end
    end

    assign m0_rvalid = r_rd_pend && !r_rd_owner;
    assign m1_rvalid = r_rd_pend &&  r_rd_owner;
    assign m0_rdata  = m0_rvalid ? ReadDataMem : '0;
    assign m1_rdata  = m1_rvalid ? ReadDataMem : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a transaction-level
// model of arbitration, double-word sequencing and read return.
module tb_dmem_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            m0_req, m0_we, m0_dbl, m1_req, m1_we, m1_dbl;
    logic [AW-1:0]   m0_addr, m1_addr, A;
    logic [2*DW-1:0] m0_wdata, m1_wdata;
    logic            m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0]   m0_rdata, m1_rdata, Data2Mem, ReadDataMem;
    logic            CEN, WEN, OEN;
    logic [4:0]      ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctl = {m0_gnt, m1_gnt, CEN, WEN, OEN};

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_dbl(m0_dbl), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_dbl(m1_dbl), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
        .ReadDataMem(ReadDataMem)
    );

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_dbl = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_dbl = 0; m1_addr = '0; m1_wdata = '0;
        ReadDataMem = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        m0_req = 1; m0_addr = 7'h05; m1_req = 1; m1_addr = 7'h06;
        #2;
        checks++; if (ctl !== 5'b00111) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 5'b00111); end
        checks++; if (A !== '0 || Data2Mem !== '0) begin errors++; $display("FAIL reset_bus got A=%h D=%h exp 0 0", A, Data2Mem); end
        step();
        checks++; if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin errors++;
            $display("FAIL reset_rvalid got %b%b exp 00", m0_rvalid, m1_rvalid); end
        checks++; if (ctl !== 5'b00111) begin errors++; $display("FAIL reset_ctl_held got %b exp %b", ctl, 5'b00111); end
        idle_inputs();
        rst_n = 1'b0;
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_we = 0; m0_dbl = 0; m0_addr = 7'h05;
        #4;
        checks++; if (ctl !== 5'b10010 || A !== 7'h05) begin errors++;
            $display("FAIL single_issue got ctl=%b A=%h exp ctl=10010 A=05", ctl, A); end
        step();
        m0_req = 0; ReadDataMem = 32'hDEADBEEF;
        #4;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'hDEADBEEF || m1_rdata !== '0) begin errors++;
            $display("FAIL single_return got rv=%b%b rd0=%h rd1=%h exp rv=10 rd0=deadbeef rd1=0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata); end
        checks++; if (ctl !== 5'b00111) begin errors++; $display("FAIL single_idle got %b exp 00111", ctl); end
        step();
    endtask

    task automatic test_dbl_write();
        m1_req = 1; m1_we = 1; m1_dbl = 1; m1_addr = 7'h10; m1_wdata = 64'h11112222_33334444;
        #4;
        checks++; if (ctl !== 5'b00001 || A !== 7'h10 || Data2Mem !== 32'h33334444) begin errors++;
            $display("FAIL dbl_wr_beat0 got ctl=%b A=%h D=%h exp ctl=00001 A=10 D=33334444", ctl, A, Data2Mem); end
        step();
        #4;
        checks++; if (ctl !== 5'b01001 || A !== 7'h11 || Data2Mem !== 32'h11112222) begin errors++;
            $display("FAIL dbl_wr_beat1 got ctl=%b A=%h D=%h exp ctl=01001 A=11 D=11112222", ctl, A, Data2Mem); end
        step();
        idle_inputs();
        #4;
        checks++; if (ctl !== 5'b00111 || {m0_rvalid, m1_rvalid} !== 2'b00) begin errors++;
            $display("FAIL dbl_wr_after got ctl=%b rv=%b%b exp ctl=00111 rv=00", ctl, m0_rvalid, m1_rvalid); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rdm;
        logic [4:0]    exp_ctl;
        rst_n = 1'b1; step(); rst_n = 1'b0;
        m0_req = 1; m0_addr = 7'h40; m1_req = 1; m1_addr = 7'h41;
        for (int k = 0; k < 5; k++) begin
            rdm = $urandom; ReadDataMem = rdm;
            if (k == 4) begin m0_req = 0; m1_req = 0; end
            exp_ctl = (k == 4) ? 5'b00111 : ((k % 2 == 0) ? 5'b10010 : 5'b01010);
            #4;
            checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL rr_order k=%0d got %b exp %b", k, ctl, exp_ctl); end
            if (k < 4) begin
                checks++; if (A !== ((k % 2 == 0) ? 7'h40 : 7'h41)) begin errors++; $display("FAIL rr_addr k=%0d got %h", k, A); end
            end
            if (k > 0) begin
                checks++;
                if ({m0_rvalid, m1_rvalid} !== ((k % 2 == 1) ? 2'b10 : 2'b01) ||
                    (k % 2 == 1 && (m0_rdata !== rdm || m1_rdata !== '0)) ||
                    (k % 2 == 0 && (m1_rdata !== rdm || m0_rdata !== '0))) begin errors++;
                    $display("FAIL rr_return k=%0d got rv=%b%b rd0=%h rd1=%h mem=%h", k, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, rdm); end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        m0_req = 1; m0_we = 0; m0_dbl = 1; m0_addr = 7'h7F;
        m1_req = 1; m1_we = 0; m1_dbl = 0; m1_addr = 7'h20;
        ReadDataMem = 32'hA0A0A0A0;
        #4;
        checks++; if (ctl !== 5'b00010 || A !== 7'h7F) begin errors++; $display("FAIL wrap_beat0 got ctl=%b A=%h exp 00010 7f", ctl, A); end
        step();
        ReadDataMem = 32'hB1B1B1B1;
        #4;
        checks++; if (ctl !== 5'b10010 || A !== 7'h00) begin errors++; $display("FAIL wrap_beat1 got ctl=%b A=%h exp 10010 00", ctl, A); end
        checks++; if (m0_rvalid !== 1 || m1_rvalid !== 0 || m0_rdata !== 32'hB1B1B1B1) begin errors++;
            $display("FAIL wrap_rv0 got rv=%b%b rd0=%h exp 10 b1b1b1b1", m0_rvalid, m1_rvalid, m0_rdata); end
        step();
        m0_req = 0; ReadDataMem = 32'hC2C2C2C2;
        #4;
        checks++; if (ctl !== 5'b01010 || A !== 7'h20) begin errors++; $display("FAIL wrap_m1_next got ctl=%b A=%h exp 01010 20", ctl, A); end
        checks++; if (m0_rvalid !== 1 || m1_rvalid !== 0 || m0_rdata !== 32'hC2C2C2C2) begin errors++;
            $display("FAIL wrap_rv1 got rv=%b%b rd0=%h exp 10 c2c2c2c2", m0_rvalid, m1_rvalid, m0_rdata); end
        step();
        m1_req = 0; ReadDataMem = 32'hD3D3D3D3;
        #4;
        checks++; if (ctl !== 5'b00111 || m1_rvalid !== 1 || m0_rvalid !== 0 || m1_rdata !== 32'hD3D3D3D3) begin errors++;
            $display("FAIL wrap_m1_ret got ctl=%b rv=%b%b rd1=%h", ctl, m0_rvalid, m1_rvalid, m1_rdata); end
        step();
    endtask

    task automatic test_reset_burst();
        idle_inputs();
        m0_req = 1; m0_dbl = 1; m0_addr = 7'h30;
        #4;
        checks++; if (ctl !== 5'b00010 || A !== 7'h30) begin errors++; $display("FAIL rb_beat0 got ctl=%b A=%h", ctl, A); end
        step();
        rst_n = 1'b1;
        m1_req = 1; m1_addr = 7'h31;
        #1;
        checks++; if (ctl !== 5'b00111 || A !== '0 || m0_rvalid !== 0 || m1_rvalid !== 0) begin errors++;
            $display("FAIL rb_abort got ctl=%b A=%h rv=%b%b exp 00111 00 00", ctl, A, m0_rvalid, m1_rvalid); end
        step();
        checks++; if (ctl !== 5'b00111 || m0_rvalid !== 0 || m1_rvalid !== 0) begin errors++;
            $display("FAIL rb_quiet got ctl=%b rv=%b%b", ctl, m0_rvalid, m1_rvalid); end
        rst_n = 1'b0;
        #4;
        checks++; if (ctl !== 5'b00010 || A !== 7'h30) begin errors++; $display("FAIL rb_first got ctl=%b A=%h exp 00010 30", ctl, A); end
        step();
        #4;
        checks++; if (ctl !== 5'b10010 || A !== 7'h31) begin errors++; $display("FAIL rb_second got ctl=%b A=%h exp 10010 31", ctl, A); end
        step();
        m0_req = 0;
        #4;
        checks++; if (ctl !== 5'b01010) begin errors++; $display("FAIL rb_m1 got ctl=%b exp 01010", ctl); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        logic            rq[2], rwe[2], rdb[2];
        logic [AW-1:0]   rad[2];
        logic [2*DW-1:0] rwd[2];
        int              wt[2];
        logic            last, burst, bown, pend, pown, iss, o, beat;
        logic [1:0]      eg;
        logic [DW-1:0]   rdm, exp_d, exp_rd0, exp_rd1;
        logic [AW-1:0]   exp_a;
        logic [2:0]      stb;
        logic [4:0]      exp_ctl;
        rst_n = 1'b1; idle_inputs(); step(); rst_n = 1'b0;
        last = 1; burst = 0; bown = 0; pend = 0; pown = 0;
        for (int p = 0; p < 2; p++) begin rq[p] = 0; wt[p] = 0; rwe[p] = 0; rdb[p] = 0; rad[p] = '0; rwd[p] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] && $urandom_range(0, 3) != 0) begin
                    rq[p] = 1; rwe[p] = 1'($urandom); rdb[p] = 1'($urandom);
                    rad[p] = ($urandom_range(0, 5) == 0) ? 7'h7F : AW'($urandom);
                    rwd[p] = {$urandom, $urandom};
                end
            end
            m0_req = rq[0]; m0_we = rwe[0]; m0_dbl = rdb[0]; m0_addr = rad[0]; m0_wdata = rwd[0];
            m1_req = rq[1]; m1_we = rwe[1]; m1_dbl = rdb[1]; m1_addr = rad[1]; m1_wdata = rwd[1];
            rdm = $urandom; ReadDataMem = rdm;
            // model: a burst in progress finishes first, else pick by round robin
            iss = 1; beat = 0; o = 0;
            if (burst) begin o = bown; beat = 1; end
            else if (rq[0] && rq[1]) o = ~last;
            else if (rq[0] || rq[1]) o = rq[1];
            else iss = 0;
            eg = '0;
            if (iss && (beat || !rdb[o])) eg[o] = 1'b1;
            exp_a   = iss ? rad[o] + AW'(beat) : '0;
            exp_d   = (iss && rwe[o]) ? (beat ? rwd[o][2*DW-1:DW] : rwd[o][DW-1:0]) : '0;
            stb     = !iss ? 3'b111 : (rwe[o] ? 3'b001 : 3'b010);
            exp_ctl = {eg[0], eg[1], stb};
            exp_rd0 = (pend && !pown) ? rdm : '0;
            exp_rd1 = (pend &&  pown) ? rdm : '0;
            #4;
            checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL rnd_ctl cyc=%0d got %b exp %b", cyc, ctl, exp_ctl); end
            checks++; if (A !== exp_a) begin errors++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", cyc, A, exp_a); end
            if (!(iss && !rwe[o])) begin
                checks++; if (Data2Mem !== exp_d) begin errors++; $display("FAIL rnd_wdata cyc=%0d got %h exp %h", cyc, Data2Mem, exp_d); end
            end
            checks++; if ({m0_rvalid, m1_rvalid} !== {pend && !pown, pend && pown}) begin errors++;
                $display("FAIL rnd_rvalid cyc=%0d got %b%b exp %b%b", cyc, m0_rvalid, m1_rvalid, pend && !pown, pend && pown); end
            checks++; if (m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin errors++;
                $display("FAIL rnd_rdata cyc=%0d got %h %h exp %h %h", cyc, m0_rdata, m1_rdata, exp_rd0, exp_rd1); end
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && !((p == 0) ? m0_gnt : m1_gnt)) wt[p]++;
                else wt[p] = 0;
                if (rq[p]) begin
                    checks++; if (wt[p] > 3) begin errors++; $display("FAIL rnd_wait port=%0d cyc=%0d got %0d exp <=3", p, cyc, wt[p]); end
                end
            end
            pend = iss && !rwe[o]; pown = o;
            if (|eg) begin last = o; rq[o] = 0; burst = 0; end
            else if (iss && !beat && rdb[o]) begin burst = 1; bown = o; end
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        step();
        test_single_read();
        test_dbl_write();
        test_back_to_back();
        test_wrap();
        test_reset_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
